// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the ROM and buffers {pc, inst} for ID.
// Define IFETCH_ALIGN_CHK_EN to trap misaligned fetches and halt until flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_exc,
  input  logic        id_ready
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          ce_q, ce_d;
  logic          sp_q, sp_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_pop;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_rem;

  logic [31:0] mpc_q   [BUF_DEPTH];
  logic [31:0] minst_q [BUF_DEPTH];
  logic        mexc_q  [BUF_DEPTH];

  logic [31:0] hpc_q, hpc_d;
  logic [31:0] hinst_q, hinst_d;
  logic        hexc_q, hexc_d;

  logic        pop, fire, we, mis;
  logic [31:0] f_inst;

  assign pop     = (cnt_q != '0) & id_ready;
  assign cnt_rem = cnt_q - CW'(pop);
  assign rd_pop  = rd_q + AW'(pop);
  assign fire    = ce_q & ~stall & ~flush
                 & (cnt_rem < CW'(BUF_DEPTH));
  assign f_inst  = mis ? 32'h0 : rom_inst;

`ifdef IFETCH_ALIGN_CHK_EN
  logic halt_q, halt_d;

  assign mis = pc_q[1:0] != 2'b00;

  always_comb begin
    halt_d = halt_q;
    if (flush)
      halt_d = 1'b0;
    else if (fire & mis)
      halt_d = 1'b1;
    ce_d = ~halt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halt_q <= 1'b0;
    else      halt_q <= halt_d;
  end
`else
  assign mis  = 1'b0;
  assign ce_d = 1'b1;
`endif

  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    sp_d  = sp_q;
    rd_d  = rd_pop;
    wr_d  = wr_q;
    cnt_d = cnt_rem;
    we    = 1'b0;
    unique case (1'b1)
      flush: begin
        rd_d  = rd_q;
        wr_d  = rd_q;
        cnt_d = '0;
        pc_d  = new_pc;
        sp_d  = 1'b0;
      end
      (~flush & stall): begin
        pc_d = pc_q;
      end
      (~flush & ~stall & branch_flag): begin
        pc_d = branch_target;
        sp_d = 1'b0;
        if (cnt_rem != '0) begin
          // keep only the oldest entry: it is the delay slot
          cnt_d = CW'(1);
          wr_d  = rd_pop + AW'(1);
        end else if (fire) begin
          we    = 1'b1;
          wr_d  = wr_q + AW'(1);
          cnt_d = CW'(1);
        end else begin
          pc_d  = pc_q + 32'd4;
          sp_d  = 1'b1;
          tgt_d = branch_target;
        end
      end
      (~flush & ~stall & ~branch_flag): begin
        if (fire) begin
          we    = 1'b1;
          wr_d  = wr_q + AW'(1);
          cnt_d = cnt_rem + CW'(1);
          pc_d  = sp_q ? tgt_q : pc_q + 32'd4;
          sp_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    hpc_d   = hpc_q;
    hinst_d = hinst_q;
    hexc_d  = hexc_q;
    if (!flush && cnt_d != '0) begin
      if (cnt_rem != '0) begin
        hpc_d   = mpc_q[rd_pop];
        hinst_d = minst_q[rd_pop];
        hexc_d  = mexc_q[rd_pop];
      end else begin
        hpc_d   = pc_q;
        hinst_d = f_inst;
        hexc_d  = mis;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      ce_q    <= 1'b0;
      sp_q    <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      hpc_q   <= 32'h0;
      hinst_q <= 32'h0;
      hexc_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ce_q    <= ce_d;
      sp_q    <= sp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      hpc_q   <= hpc_d;
      hinst_q <= hinst_d;
      hexc_q  <= hexc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mpc_q[wr_q]   <= pc_q;
      minst_q[wr_q] <= f_inst;
      mexc_q[wr_q]  <= mis;
    end
  end

  assign rom_ce   = ce_q;
  assign rom_addr = pc_q;
  assign if_valid = cnt_q != '0;
  assign if_pc    = hpc_q;
  assign if_inst  = hinst_q;
  assign if_exc   = hexc_q;

endmodule
